// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter (core vs debug/loader)
// One grant per cycle, registered command stage, registered read response stage.
module dmem_arbiter #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 core_req_in,
    input  logic                 core_we_in,
    input  logic                 core_addr_mode_in,
    input  logic [WIDTH-1:0]     core_addr_in,
    input  logic [WIDTH-1:0]     core_wd_in,
    output logic                 core_gnt_out,
    output logic                 core_stall_out,
    output logic                 core_rvalid_out,
    output logic [WIDTH-1:0]     core_rdata_out,
    input  logic                 dbg_req_in,
    input  logic                 dbg_we_in,
    input  logic                 dbg_addr_mode_in,
    input  logic [WIDTH-1:0]     dbg_addr_in,
    input  logic [WIDTH-1:0]     dbg_wd_in,
    output logic                 dbg_gnt_out,
    output logic                 dbg_rvalid_out,
    output logic [WIDTH-1:0]     dbg_rdata_out,
    input  logic                 dbg_lock_in,
    output logic [WIDTH-1:0]     mem_a_out,
    output logic                 mem_we_out,
    output logic                 mem_addr_mode_out,
    output logic [WIDTH-1:0]     mem_wd_out,
    input  logic [WIDTH-1:0]     mem_rd_in,
    output logic [CNT_WIDTH-1:0] conflict_cnt_out
);

    typedef enum logic {OWN_CORE = 1'b0, OWN_DBG = 1'b1} owner_t;
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t               r_state;
    state_t               w_next_state;
    owner_t               r_last_owner;
    owner_t               r_cmd_port;
    logic                 r_cmd_we;
    logic                 r_cmd_mode;
    logic [WIDTH-1:0]     r_cmd_addr;
    logic [WIDTH-1:0]     r_cmd_wd;
    logic                 r_core_rvalid;
    logic                 r_dbg_rvalid;
    logic [WIDTH-1:0]     r_core_rdata;
    logic [WIDTH-1:0]     r_dbg_rdata;
    logic [CNT_WIDTH-1:0] r_conflict_cnt;
    logic                 w_core_gnt;
    logic                 w_dbg_gnt;
    logic                 w_any_gnt;
    logic                 w_both_req;
    logic                 w_rd_resp;

    // Grants are gated by reset so nothing is accepted while rst_in is low.
    always_comb begin
        w_core_gnt = 1'b0;
        w_dbg_gnt  = 1'b0;
        if (rst_in) begin
            if (dbg_lock_in) begin
                w_dbg_gnt = dbg_req_in;
            end else if (core_req_in && dbg_req_in) begin
                w_core_gnt = (r_last_owner == OWN_DBG);
                w_dbg_gnt  = (r_last_owner == OWN_CORE);
            end else begin
                w_core_gnt = core_req_in;
                w_dbg_gnt  = dbg_req_in;
            end
        end
    end

    assign w_any_gnt  = w_core_gnt | w_dbg_gnt;
    assign w_both_req = core_req_in & dbg_req_in;
    assign w_rd_resp  = (r_state == ACCESS) & ~r_cmd_we;

    always_comb begin
        w_next_state = IDLE;
        if (w_any_gnt) begin
            w_next_state = ACCESS;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Command fields hold their last value when idle so mem_* stay stable.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_last_owner <= OWN_DBG;
            r_cmd_port   <= OWN_CORE;
            r_cmd_we     <= 1'b0;
            r_cmd_mode   <= 1'b0;
            r_cmd_addr   <= '0;
            r_cmd_wd     <= '0;
        end else if (w_any_gnt) begin
            r_last_owner <= w_dbg_gnt ? OWN_DBG : OWN_CORE;
            r_cmd_port   <= w_dbg_gnt ? OWN_DBG : OWN_CORE;
            r_cmd_we     <= w_dbg_gnt ? dbg_we_in : core_we_in;
            r_cmd_mode   <= w_dbg_gnt ? dbg_addr_mode_in : core_addr_mode_in;
            r_cmd_addr   <= w_dbg_gnt ? dbg_addr_in : core_addr_in;
            r_cmd_wd     <= w_dbg_gnt ? dbg_wd_in : core_wd_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_core_rvalid <= 1'b0;
            r_dbg_rvalid  <= 1'b0;
            r_core_rdata  <= '0;
            r_dbg_rdata   <= '0;
        end else begin
            r_core_rvalid <= w_rd_resp && (r_cmd_port == OWN_CORE);
            r_dbg_rvalid  <= w_rd_resp && (r_cmd_port == OWN_DBG);
            if (w_rd_resp && (r_cmd_port == OWN_CORE)) begin
                r_core_rdata <= mem_rd_in;
            end
            if (w_rd_resp && (r_cmd_port == OWN_DBG)) begin
                r_dbg_rdata <= mem_rd_in;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_conflict_cnt <= '0;
        end else if (w_both_req && (r_conflict_cnt != {CNT_WIDTH{1'b1}})) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
        end
    end

    assign core_gnt_out      = w_core_gnt;
    assign dbg_gnt_out       = w_dbg_gnt;
    assign core_stall_out    = core_req_in & ~w_core_gnt;
    assign core_rvalid_out   = r_core_rvalid;
    assign dbg_rvalid_out    = r_dbg_rvalid;
    assign core_rdata_out    = r_core_rdata;
    assign dbg_rdata_out     = r_dbg_rdata;
    assign mem_a_out         = r_cmd_addr;
    assign mem_we_out        = (r_state == ACCESS) & r_cmd_we;
    assign mem_addr_mode_out = r_cmd_mode;
    assign mem_wd_out        = r_cmd_wd;
    assign conflict_cnt_out  = r_conflict_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
// Directed scenarios plus a randomized run against a transaction-level model.
module tb_dmem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        core_req_in, core_we_in, core_addr_mode_in;
    logic [31:0] core_addr_in, core_wd_in;
    logic        core_gnt_out, core_stall_out, core_rvalid_out;
    logic [31:0] core_rdata_out;
    logic        dbg_req_in, dbg_we_in, dbg_addr_mode_in;
    logic [31:0] dbg_addr_in, dbg_wd_in;
    logic        dbg_gnt_out, dbg_rvalid_out;
    logic [31:0] dbg_rdata_out;
    logic        dbg_lock_in;
    logic [31:0] mem_a_out, mem_wd_out, mem_rd_in;
    logic        mem_we_out, mem_addr_mode_out;
    logic [15:0] conflict_cnt_out;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic        poke_we = 1'b0;
    logic [7:0]  poke_idx = 8'd0;
    logic [31:0] poke_data = 32'd0;

    int total = 0;
    int bad = 0;

    dmem_arbiter #(.WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .core_req_in(core_req_in), .core_we_in(core_we_in),
        .core_addr_mode_in(core_addr_mode_in), .core_addr_in(core_addr_in),
        .core_wd_in(core_wd_in), .core_gnt_out(core_gnt_out),
        .core_stall_out(core_stall_out), .core_rvalid_out(core_rvalid_out),
        .core_rdata_out(core_rdata_out),
        .dbg_req_in(dbg_req_in), .dbg_we_in(dbg_we_in),
        .dbg_addr_mode_in(dbg_addr_mode_in), .dbg_addr_in(dbg_addr_in),
        .dbg_wd_in(dbg_wd_in), .dbg_gnt_out(dbg_gnt_out),
        .dbg_rvalid_out(dbg_rvalid_out), .dbg_rdata_out(dbg_rdata_out),
        .dbg_lock_in(dbg_lock_in),
        .mem_a_out(mem_a_out), .mem_we_out(mem_we_out),
        .mem_addr_mode_out(mem_addr_mode_out), .mem_wd_out(mem_wd_out),
        .mem_rd_in(mem_rd_in), .conflict_cnt_out(conflict_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    // Word-indexed memory; the write path stores the full data word.
    assign mem_rd_in = mem[mem_a_out[9:2]];
    always @(posedge clk_in) begin
        if (poke_we) mem[poke_idx] <= poke_data;
        else if (mem_we_out) mem[mem_a_out[9:2]] <= mem_wd_out;
    end

    task automatic poke(input logic [7:0] idx, input logic [31:0] data);
        poke_idx = idx; poke_data = data; poke_we = 1'b1;
        @(posedge clk_in); #1;
        poke_we = 1'b0;
    endtask

    task automatic idle_inputs();
        core_req_in = 0; core_we_in = 0; core_addr_mode_in = 0; core_addr_in = 0; core_wd_in = 0;
        dbg_req_in = 0; dbg_we_in = 0; dbg_addr_mode_in = 0; dbg_addr_in = 0; dbg_wd_in = 0;
        dbg_lock_in = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1'b0;
        core_req_in = 1; dbg_req_in = 1;
        @(negedge clk_in);
        total++; if ({core_gnt_out, dbg_gnt_out} !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", {core_gnt_out, dbg_gnt_out}); end
        total++; if ({core_rvalid_out, dbg_rvalid_out, mem_we_out} !== 3'b000) begin bad++; $display("FAIL reset_rv_we got=%b exp=000", {core_rvalid_out, dbg_rvalid_out, mem_we_out}); end
        @(posedge clk_in); #1;
        total++; if (conflict_cnt_out !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", conflict_cnt_out); end
        total++; if ({mem_a_out, mem_wd_out, mem_addr_mode_out} !== 65'd0) begin bad++; $display("FAIL reset_mem got=%h exp=0", {mem_a_out, mem_wd_out, mem_addr_mode_out}); end
        rst_in = 1'b1;
        @(negedge clk_in);
        total++; if ({core_gnt_out, dbg_gnt_out} !== 2'b10) begin bad++; $display("FAIL reset_first_contention got=%b exp=10", {core_gnt_out, dbg_gnt_out}); end
        @(posedge clk_in); #1;
        idle_inputs();
    endtask

    task automatic test_core_load();
        do_reset();
        poke(8'd4, 32'hDEADBEEF);
        core_req_in = 1; core_addr_in = 32'h10;
        @(negedge clk_in);
        total++; if (core_gnt_out !== 1'b1) begin bad++; $display("FAIL load_gnt got=%b exp=1", core_gnt_out); end
        @(posedge clk_in); #1; core_req_in = 0;
        @(negedge clk_in);
        total++; if (mem_a_out !== 32'h10 || mem_we_out !== 1'b0) begin bad++; $display("FAIL load_mem got=%h/%b exp=10/0", mem_a_out, mem_we_out); end
        total++; if (core_rvalid_out !== 1'b0) begin bad++; $display("FAIL load_rv_early got=%b exp=0", core_rvalid_out); end
        @(negedge clk_in);
        total++; if (core_rvalid_out !== 1'b1 || core_rdata_out !== 32'hDEADBEEF || dbg_rvalid_out !== 1'b0) begin bad++; $display("FAIL load_resp got=%b/%h exp=1/deadbeef", core_rvalid_out, core_rdata_out); end
        @(negedge clk_in);
        total++; if (core_rvalid_out !== 1'b0 || core_rdata_out !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rv_pulse got=%b/%h exp=0/deadbeef", core_rvalid_out, core_rdata_out); end
    endtask

    task automatic test_contention();
        do_reset();
        core_req_in = 1; core_addr_in = 32'h4;
        dbg_req_in = 1; dbg_addr_in = 32'h8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            total++; if ({core_gnt_out, dbg_gnt_out, core_stall_out} !== ((i % 2 == 0) ? 3'b100 : 3'b011)) begin
                bad++; $display("FAIL contention_%0d got=%b exp=%b", i, {core_gnt_out, dbg_gnt_out, core_stall_out}, (i % 2 == 0) ? 3'b100 : 3'b011);
            end
            @(posedge clk_in); #1;
        end
        idle_inputs();
        @(negedge clk_in);
        total++; if (conflict_cnt_out !== 16'd4) begin bad++; $display("FAIL contention_cnt got=%0d exp=4", conflict_cnt_out); end
    endtask

    task automatic test_lock();
        do_reset();
        dbg_lock_in = 1; core_req_in = 1; dbg_req_in = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            total++; if ({core_gnt_out, dbg_gnt_out, core_stall_out} !== 3'b011) begin bad++; $display("FAIL lock_%0d got=%b exp=011", i, {core_gnt_out, dbg_gnt_out, core_stall_out}); end
            @(posedge clk_in); #1;
        end
        dbg_req_in = 0;
        @(negedge clk_in);
        total++; if ({core_gnt_out, dbg_gnt_out, conflict_cnt_out} !== {2'b00, 16'd3}) begin bad++; $display("FAIL lock_idle got=%b/%0d exp=00/3", {core_gnt_out, dbg_gnt_out}, conflict_cnt_out); end
        @(posedge clk_in); #1;
        idle_inputs();
    endtask

    task automatic test_store_load();
        do_reset();
        poke(8'd8, 32'h0);
        core_req_in = 1; core_we_in = 1; core_addr_mode_in = 1; core_addr_in = 32'h20; core_wd_in = 32'h55;
        @(negedge clk_in);
        total++; if (core_gnt_out !== 1'b1) begin bad++; $display("FAIL st_gnt got=%b exp=1", core_gnt_out); end
        @(posedge clk_in); #1;
        core_we_in = 0; core_addr_mode_in = 0; core_wd_in = 0;
        @(negedge clk_in);
        total++; if ({mem_we_out, mem_addr_mode_out, mem_a_out, mem_wd_out} !== {2'b11, 32'h20, 32'h55}) begin
            bad++; $display("FAIL st_mem got=%b%b/%h/%h exp=11/20/55", mem_we_out, mem_addr_mode_out, mem_a_out, mem_wd_out);
        end
        total++; if (core_gnt_out !== 1'b1) begin bad++; $display("FAIL ld_gnt got=%b exp=1", core_gnt_out); end
        @(posedge clk_in); #1; core_req_in = 0;
        @(negedge clk_in);
        total++; if ({mem_we_out, core_rvalid_out} !== 2'b00) begin bad++; $display("FAIL st_no_rvalid got=%b exp=00", {mem_we_out, core_rvalid_out}); end
        @(negedge clk_in);
        total++; if (core_rvalid_out !== 1'b1 || core_rdata_out !== 32'h55) begin bad++; $display("FAIL raw_resp got=%b/%h exp=1/55", core_rvalid_out, core_rdata_out); end
    endtask

    task automatic test_reset_mid();
        for (int w = 1; w >= 0; w--) begin
            do_reset();
            poke(8'd16, 32'hAAAA0000);
            core_req_in = 1; core_we_in = w[0]; core_addr_in = 32'h40; core_wd_in = 32'h1234;
            @(posedge clk_in); #1;
            idle_inputs();
            rst_in = 1'b0;
            #1;
            total++; if (mem_we_out !== 1'b0) begin bad++; $display("FAIL rstmid_we_%0d got=%b exp=0", w, mem_we_out); end
            @(posedge clk_in); #1 rst_in = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk_in);
                total++; if ({core_rvalid_out, mem_we_out} !== 2'b00) begin bad++; $display("FAIL rstmid_rv_%0d_%0d got=%b exp=00", w, i, {core_rvalid_out, mem_we_out}); end
            end
            total++; if (mem[16] !== 32'hAAAA0000) begin bad++; $display("FAIL rstmid_mem_%0d got=%h exp=aaaa0000", w, mem[16]); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        core_req_in = 1; dbg_req_in = 1;
        repeat (65534) @(posedge clk_in);
        @(negedge clk_in);
        total++; if (conflict_cnt_out !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", conflict_cnt_out); end
        @(negedge clk_in);
        total++; if (conflict_cnt_out !== 16'hFFFF) begin bad++; $display("FAIL sat_hit got=%h exp=ffff", conflict_cnt_out); end
        repeat (6) @(negedge clk_in);
        total++; if (conflict_cnt_out !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", conflict_cnt_out); end
        idle_inputs();
    endtask

    // Model: pending request per port, a granted-command slot and a read-response slot.
    task automatic test_random();
        logic        p_req [2];
        logic        p_we [2];
        logic        p_mode [2];
        logic [31:0] p_addr [2];
        logic [31:0] p_wd [2];
        logic [31:0] last_rd [2];
        logic        eg [2];
        logic        last_dbg, lock;
        int          cnt;
        int          gp;
        logic        s1_v, s1_we, s1_mode;
        int          s1_port;
        logic [31:0] s1_addr, s1_wd, rdval;
        logic        s2_v, s2_we;
        int          s2_port;
        logic [31:0] s2_data;
        do_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int p = 0; p < 2; p++) begin p_req[p] = 0; last_rd[p] = 0; p_we[p] = 0; p_mode[p] = 0; p_addr[p] = 0; p_wd[p] = 0; end
        last_dbg = 1; cnt = 0; s1_v = 0; s2_v = 0; s1_we = 0; s1_mode = 0; s1_port = 0;
        s1_addr = 0; s1_wd = 0; s2_we = 0; s2_port = 0; s2_data = 0; rdval = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_req[p] && $urandom_range(0, 9) < 6) begin
                    p_req[p] = 1; p_we[p] = $urandom_range(0, 2) == 0; p_mode[p] = $urandom_range(0, 1) == 1;
                    p_addr[p] = 32'($urandom_range(0, 255)) << 2; p_wd[p] = $urandom;
                end
            end
            lock = $urandom_range(0, 9) == 0;
            core_req_in = p_req[0]; core_we_in = p_we[0]; core_addr_mode_in = p_mode[0]; core_addr_in = p_addr[0]; core_wd_in = p_wd[0];
            dbg_req_in = p_req[1]; dbg_we_in = p_we[1]; dbg_addr_mode_in = p_mode[1]; dbg_addr_in = p_addr[1]; dbg_wd_in = p_wd[1];
            dbg_lock_in = lock;
            @(negedge clk_in);
            if (lock) begin eg[0] = 0; eg[1] = p_req[1]; end
            else if (p_req[0] && p_req[1]) begin eg[0] = last_dbg; eg[1] = !last_dbg; end
            else begin eg[0] = p_req[0]; eg[1] = p_req[1]; end
            total++; if ({core_gnt_out, dbg_gnt_out, core_stall_out} !== {eg[0], eg[1], p_req[0] & !eg[0]}) begin
                bad++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, {core_gnt_out, dbg_gnt_out, core_stall_out}, {eg[0], eg[1], p_req[0] & !eg[0]});
            end
            if (s1_v) begin
                total++; if ({mem_a_out, mem_we_out, mem_addr_mode_out, mem_wd_out} !== {s1_addr, s1_we, s1_mode, s1_wd}) begin
                    bad++; $display("FAIL rnd_mem c=%0d got=%h/%b/%b/%h exp=%h/%b/%b/%h", c, mem_a_out, mem_we_out, mem_addr_mode_out, mem_wd_out, s1_addr, s1_we, s1_mode, s1_wd);
                end
                if (s1_we) ref_mem[s1_addr[9:2]] = s1_wd;
                else rdval = ref_mem[s1_addr[9:2]];
            end else begin
                total++; if (mem_we_out !== 1'b0) begin bad++; $display("FAIL rnd_idle_we c=%0d got=%b exp=0", c, mem_we_out); end
            end
            if (s2_v && !s2_we) last_rd[s2_port] = s2_data;
            total++; if ({core_rvalid_out, dbg_rvalid_out} !== {s2_v && !s2_we && s2_port == 0, s2_v && !s2_we && s2_port == 1}) begin
                bad++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, {core_rvalid_out, dbg_rvalid_out}, {s2_v && !s2_we && s2_port == 0, s2_v && !s2_we && s2_port == 1});
            end
            total++; if (core_rdata_out !== last_rd[0] || dbg_rdata_out !== last_rd[1]) begin
                bad++; $display("FAIL rnd_rdata c=%0d got=%h/%h exp=%h/%h", c, core_rdata_out, dbg_rdata_out, last_rd[0], last_rd[1]);
            end
            total++; if (conflict_cnt_out !== 16'(cnt)) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, conflict_cnt_out, cnt); end
            if (p_req[0] && p_req[1] && cnt < 65535) cnt++;
            s2_v = s1_v; s2_we = s1_we; s2_port = s1_port; s2_data = rdval;
            s1_v = eg[0] | eg[1];
            if (s1_v) begin
                gp = eg[1] ? 1 : 0;
                s1_port = gp; s1_we = p_we[gp]; s1_mode = p_mode[gp]; s1_addr = p_addr[gp]; s1_wd = p_wd[gp];
                last_dbg = eg[1];
                p_req[gp] = 0;
            end
            @(posedge clk_in); #1;
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_in = 1'b0;
        for (int i = 0; i < 256; i++) poke(8'(i), $urandom);
        test_reset();
        test_core_load();
        test_contention();
        test_lock();
        test_store_load();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
